// File: rtl/minterm_sweep_pkg.sv
// Shared types and constants for the minterm sweep stimulus/capture block.
package minterm_pkg;

  localparam int unsigned NUM_MINTERMS = 16;
  localparam int unsigned IDX_W        = 4;

  localparam logic [NUM_MINTERMS-1:0] EXPECT_DEFAULT = 16'h0DD0;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/minterm_sweep_if.sv
// Stimulus/capture bundle between minterm_sweep (master) and the block under sweep.
// Match exists only when MINTERM_SWEEP_CHECK_EN is defined.
interface minterm_sweep_if;
  import minterm_pkg::*;

  logic                    Start;
  logic                    Abort;
  logic                    F;
  logic                    En;
  logic                    A;
  logic                    B;
  logic                    C;
  logic                    D;
  logic                    Busy;
  logic                    Done;
  logic [NUM_MINTERMS-1:0] Table;
`ifdef MINTERM_SWEEP_CHECK_EN
  logic                    Match;
`endif

`ifdef MINTERM_SWEEP_CHECK_EN
  modport master (
    input  Start, Abort, F,
    output En, A, B, C, D, Busy, Done, Table, Match
  );
  modport slave (
    output Start, Abort, F,
    input  En, A, B, C, D, Busy, Done, Table, Match
  );
`else
  modport master (
    input  Start, Abort, F,
    output En, A, B, C, D, Busy, Done, Table
  );
  modport slave (
    output Start, Abort, F,
    input  En, A, B, C, D, Busy, Done, Table
  );
`endif

endinterface

// File: rtl/minterm_sweep_settle_cnt.sv
// Loadable down-counter with clear; tc flags a zero count (end of settle dwell).
module settle_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/minterm_sweep.sv
// Sweeps En/A..D through all 16 minterms, captures F into Table, pulses Done.
// Optional MINTERM_SWEEP_CHECK_EN adds a Match flag comparing Table to EXPECT.
module minterm_sweep
  import minterm_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
`ifdef MINTERM_SWEEP_CHECK_EN
  , parameter logic [NUM_MINTERMS-1:0] EXPECT = EXPECT_DEFAULT
`endif
) (
  input  logic           Clk,
  input  logic           Rst,
  minterm_sweep_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MINTERMS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_MINTERMS-1:0] table_q, table_d;
  logic                    en_q, en_d;
  logic [IDX_W-1:0]        abcd_q, abcd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    match_q, match_d;
  logic                    cnt_clr, cnt_load, cnt_dec, cnt_tc;

  settle_cnt #(.W(IDX_W)) u_settle_cnt (
    .clk      (Clk),
    .rst      (Rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (IDX_W'(SETTLE_CYC - 1)),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    table_d  = table_q;
    match_d  = match_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Start && !bus.Abort) begin
          state_d  = SETTLE;
          idx_d    = '0;
          table_d  = '0;
          match_d  = 1'b0;
          cnt_load = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_tc)
          state_d = SAMPLE;
        else
          cnt_dec = 1'b1;
      end
      SAMPLE: begin
        table_d[idx_q] = bus.F;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
`ifdef MINTERM_SWEEP_CHECK_EN
          // Judged on the completed table so Match is valid alongside Done.
          match_d = (table_d == EXPECT);
`endif
        end else begin
          state_d  = SETTLE;
          idx_d    = idx_q + 1'b1;
          cnt_load = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides the transition but keeps a sample taken this cycle.
    if (bus.Abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      match_d = 1'b0;
      cnt_clr = 1'b1;
    end

    en_d   = (state_d == SETTLE) || (state_d == SAMPLE);
    abcd_d = en_d ? idx_d : '0;
    busy_d = en_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      en_q    <= 1'b0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      en_q    <= en_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign bus.En    = en_q;
  assign bus.A     = abcd_q[3];
  assign bus.B     = abcd_q[2];
  assign bus.C     = abcd_q[1];
  assign bus.D     = abcd_q[0];
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Table = table_q;
`ifdef MINTERM_SWEEP_CHECK_EN
  assign bus.Match = match_q;
`else
  logic unused_match;
  assign unused_match = match_q;
`endif

endmodule
